// File: rtl/sht40_sequencer_pkg.sv
// Shared encodings and constants for the SHT40 measurement sequencer.
package sht40_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CMD      = 3'd1,
      ST_CMD_WAIT = 3'd2,
      ST_MEAS_DLY = 3'd3,
      ST_RD       = 3'd4,
      ST_RD_WAIT  = 3'd5,
      ST_CHECK    = 3'd6
   } state_e;

   localparam logic [6:0] SHT_ADDR    = 7'h44;
   localparam logic [7:0] MEAS_CMD    = 8'hFD;
   localparam logic [7:0] CRC_POLY    = 8'h31;
   localparam logic [7:0] CRC_INIT    = 8'hFF;
   localparam logic [2:0] WRITE_COUNT = 3'd1;
   localparam logic [3:0] READ_COUNT  = 4'd6;
   localparam logic [2:0] RX_FULL     = 3'd6;

endpackage

// File: rtl/sht40_crc8.sv
// Combinational Sensirion CRC-8 (poly 0x31, init 0xFF, MSB first) of one 16-bit word.
module sht40_crc8
   import sht40_sequencer_pkg::*;
(
   input  logic [15:0] data_i,
   output logic [7:0]  crc_o
);

   logic [7:0] crc;
   logic       fb;

   always_comb begin
      crc = CRC_INIT;
      fb  = 1'b0;
      for (int i = 15; i >= 0; i--) begin
         fb  = crc[7] ^ data_i[i];
         crc = {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
      end
      crc_o = crc;
   end

endmodule

// File: rtl/sht40_sequencer.sv
// Drives an I2C master through SHT40 measure-command / wait / 6-byte read cycles,
// checks both CRCs and publishes the raw temperature and humidity words.
module sht40_sequencer #(
   parameter logic [6:0] SHT_ADDR  = sht40_sequencer_pkg::SHT_ADDR,
   parameter logic [7:0] MEAS_CMD  = sht40_sequencer_pkg::MEAS_CMD,
   parameter int         MEAS_WAIT = 200000,
   parameter int         PERIOD    = 20000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        Start_Req,
   input  logic        Auto_En,
   output logic        Processor_Ready,
   output logic [6:0]  Peripheral_Address,
   output logic        r_or_w,
   output logic [7:0]  Tx_Byte,
   output logic [2:0]  i2c_writes,
   output logic [3:0]  SHT_Reads,
   input  logic        Master_Done,
   input  logic        Master_Nack,
   input  logic        Rx_Valid,
   input  logic [7:0]  Rx_Byte,
   output logic        Busy,
   output logic [15:0] Temp_Raw,
   output logic [15:0] Hum_Raw,
   output logic        Data_Valid,
   output logic        Crc_Error,
   output logic        Nack_Error
);
   import sht40_sequencer_pkg::*;

   localparam int DW = (MEAS_WAIT > 1) ? $clog2(MEAS_WAIT) : 1;
   localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [DW-1:0] DLY_LAST = DW'(MEAS_WAIT - 1);
   localparam logic [PW-1:0] PER_LAST = PW'(PERIOD - 1);

   state_e        state_q, state_d;
   logic [DW-1:0] dly_q, dly_d;
   logic [PW-1:0] per_q, per_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    buf_q [0:5];
   logic [7:0]    buf_d [0:5];
   logic [15:0]   temp_q, temp_d;
   logic [15:0]   hum_q, hum_d;
   logic          ready_q, ready_d;
   logic          rw_q, rw_d;
   logic          dv_q, dv_d;
   logic          crc_err_q, crc_err_d;
   logic          nack_err_q, nack_err_d;
   logic          auto_tick;
   logic [7:0]    crc_t, crc_h;

   sht40_crc8 u_crc_temp (.data_i({buf_q[0], buf_q[1]}), .crc_o(crc_t));
   sht40_crc8 u_crc_hum  (.data_i({buf_q[3], buf_q[4]}), .crc_o(crc_h));

   // The period timer saturates, so a tick that lands while busy stays pending.
   assign auto_tick = Auto_En && (per_q == PER_LAST);

   always_comb begin
      state_d    = state_q;
      dly_d      = dly_q;
      per_d      = per_q;
      idx_d      = idx_q;
      buf_d      = buf_q;
      temp_d     = temp_q;
      hum_d      = hum_q;
      ready_d    = 1'b0;
      rw_d       = rw_q;
      dv_d       = 1'b0;
      crc_err_d  = 1'b0;
      nack_err_d = 1'b0;

      if (!Auto_En) begin
         per_d = '0;
      end else if (per_q != PER_LAST) begin
         per_d = per_q + 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (Start_Req || auto_tick) begin
               state_d = ST_CMD;
            end
            if (auto_tick) begin
               per_d = '0;
            end
         end
         ST_CMD: begin
            ready_d = 1'b1;
            rw_d    = 1'b0;
            state_d = ST_CMD_WAIT;
         end
         ST_CMD_WAIT: begin
            if (Master_Nack) begin
               nack_err_d = 1'b1;
               state_d    = ST_IDLE;
            end else if (Master_Done) begin
               dly_d   = '0;
               state_d = ST_MEAS_DLY;
            end
         end
         ST_MEAS_DLY: begin
            if (dly_q == DLY_LAST) begin
               state_d = ST_RD;
            end else begin
               dly_d = dly_q + 1'b1;
            end
         end
         ST_RD: begin
            ready_d = 1'b1;
            rw_d    = 1'b1;
            idx_d   = '0;
            state_d = ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            if (Rx_Valid && (idx_q != RX_FULL)) begin
               buf_d[idx_q] = Rx_Byte;
               idx_d        = idx_q + 1'b1;
            end
            if (Master_Nack) begin
               nack_err_d = 1'b1;
               state_d    = ST_IDLE;
            end else if (Master_Done) begin
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if ((idx_q == RX_FULL) && (crc_t == buf_q[2]) && (crc_h == buf_q[5])) begin
               temp_d = {buf_q[0], buf_q[1]};
               hum_d  = {buf_q[3], buf_q[4]};
               dv_d   = 1'b1;
            end else begin
               crc_err_d = 1'b1;
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         dly_q      <= '0;
         per_q      <= '0;
         idx_q      <= '0;
         for (int i = 0; i < 6; i++) begin
            buf_q[i] <= '0;
         end
         temp_q     <= '0;
         hum_q      <= '0;
         ready_q    <= 1'b0;
         rw_q       <= 1'b0;
         dv_q       <= 1'b0;
         crc_err_q  <= 1'b0;
         nack_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         dly_q      <= dly_d;
         per_q      <= per_d;
         idx_q      <= idx_d;
         buf_q      <= buf_d;
         temp_q     <= temp_d;
         hum_q      <= hum_d;
         ready_q    <= ready_d;
         rw_q       <= rw_d;
         dv_q       <= dv_d;
         crc_err_q  <= crc_err_d;
         nack_err_q <= nack_err_d;
      end
   end

   assign Processor_Ready    = ready_q;
   assign r_or_w             = rw_q;
   assign Tx_Byte            = MEAS_CMD;
   assign Peripheral_Address = SHT_ADDR;
   assign i2c_writes         = WRITE_COUNT;
   assign SHT_Reads          = READ_COUNT;
   assign Busy               = (state_q != ST_IDLE);
   assign Temp_Raw           = temp_q;
   assign Hum_Raw            = hum_q;
   assign Data_Valid         = dv_q;
   assign Crc_Error          = crc_err_q;
   assign Nack_Error         = nack_err_q;

endmodule

// File: tb/tb_sht40_sequencer.sv
// Directed bench for sht40_sequencer with MEAS_WAIT=50 and PERIOD=1000.
module tb_sht40_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        Start_Req = 1'b0;
   logic        Auto_En = 1'b0;
   logic        Processor_Ready;
   logic [6:0]  Peripheral_Address;
   logic        r_or_w;
   logic [7:0]  Tx_Byte;
   logic [2:0]  i2c_writes;
   logic [3:0]  SHT_Reads;
   logic        Master_Done = 1'b0;
   logic        Master_Nack = 1'b0;
   logic        Rx_Valid = 1'b0;
   logic [7:0]  Rx_Byte = 8'h00;
   logic        Busy;
   logic [15:0] Temp_Raw;
   logic [15:0] Hum_Raw;
   logic        Data_Valid;
   logic        Crc_Error;
   logic        Nack_Error;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   localparam logic [47:0] GOOD    = 48'hBEEF92_666693;
   localparam logic [47:0] BAD_CRC = 48'hBEEF93_666693;

   sht40_sequencer #(
      .MEAS_WAIT(50),
      .PERIOD(1000)
   ) dut (
      .clk(clk), .rst(rst), .Start_Req(Start_Req), .Auto_En(Auto_En),
      .Processor_Ready(Processor_Ready), .Peripheral_Address(Peripheral_Address),
      .r_or_w(r_or_w), .Tx_Byte(Tx_Byte), .i2c_writes(i2c_writes), .SHT_Reads(SHT_Reads),
      .Master_Done(Master_Done), .Master_Nack(Master_Nack), .Rx_Valid(Rx_Valid),
      .Rx_Byte(Rx_Byte), .Busy(Busy), .Temp_Raw(Temp_Raw), .Hum_Raw(Hum_Raw),
      .Data_Valid(Data_Valid), .Crc_Error(Crc_Error), .Nack_Error(Nack_Error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for a Processor_Ready pulse; n is the number of clock edges waited.
   task automatic wait_ready(input string name, input int limit, output int n);
      n = 0;
      while (Processor_Ready !== 1'b1 && n < limit) begin
         tick();
         n++;
      end
      if (Processor_Ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: no Processor_Ready within %0d cycles", name, limit);
      end
   endtask

   task automatic pulse_done();
      Master_Done = 1'b1;
      tick();
      Master_Done = 1'b0;
   endtask

   task automatic start_meas(input string name);
      int n;
      Start_Req = 1'b1;
      tick();
      Start_Req = 1'b0;
      wait_ready(name, 10, n);
   endtask

   // Write phase done, delay, read phase, nb bytes then Master_Done; leaves state in CHECK.
   task automatic serve_read(input string name, input logic [47:0] b, input int nb);
      int n;
      pulse_done();
      wait_ready(name, 80, n);
      for (int i = 0; i < nb; i++) begin
         Rx_Valid = 1'b1;
         Rx_Byte  = (i < 6) ? b[47 - 8*i -: 8] : 8'h00;
         tick();
      end
      Rx_Valid = 1'b0;
      pulse_done();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", Busy); end
      checks++; if (Processor_Ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b want 0", Processor_Ready); end
      checks++; if ({Data_Valid, Crc_Error, Nack_Error} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b want 000", {Data_Valid, Crc_Error, Nack_Error}); end
      checks++; if ({Temp_Raw, Hum_Raw} !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 00000000", {Temp_Raw, Hum_Raw}); end
      checks++; if (Peripheral_Address !== 7'h44) begin errors++; $display("FAIL addr got %h want 44", Peripheral_Address); end
      checks++; if ({i2c_writes, SHT_Reads} !== {3'd1, 4'd6}) begin errors++; $display("FAIL counts got %0d/%0d want 1/6", i2c_writes, SHT_Reads); end
      rst = 1'b0;
      tick();
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %0b want 0", Busy); end
   endtask

   task automatic test_good_read();
      int n;
      start_meas("good_write");
      checks++; if (r_or_w !== 1'b0) begin errors++; $display("FAIL write_rw got %0b want 0", r_or_w); end
      checks++; if (Tx_Byte !== 8'hFD) begin errors++; $display("FAIL tx_byte got %h want fd", Tx_Byte); end
      checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL busy got %0b want 1", Busy); end
      pulse_done();
      wait_ready("good_read", 80, n);
      checks++; if (n + 1 !== 52) begin errors++; $display("FAIL read_latency got %0d want 52", n + 1); end
      checks++; if (r_or_w !== 1'b1) begin errors++; $display("FAIL read_rw got %0b want 1", r_or_w); end
      for (int i = 0; i < 6; i++) begin
         Rx_Valid = 1'b1;
         Rx_Byte  = GOOD[47 - 8*i -: 8];
         tick();
      end
      Rx_Valid = 1'b0;
      pulse_done();
      tick();
      checks++; if (Data_Valid !== 1'b1) begin errors++; $display("FAIL good_dv got %0b want 1", Data_Valid); end
      checks++; if (Crc_Error !== 1'b0) begin errors++; $display("FAIL good_crc_err got %0b want 0", Crc_Error); end
      checks++; if (Temp_Raw !== 16'hBEEF) begin errors++; $display("FAIL good_temp got %h want beef", Temp_Raw); end
      checks++; if (Hum_Raw !== 16'h6666) begin errors++; $display("FAIL good_hum got %h want 6666", Hum_Raw); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL good_idle got %0b want 0", Busy); end
      tick();
      checks++; if (Data_Valid !== 1'b0) begin errors++; $display("FAIL dv_one_cycle got %0b want 0", Data_Valid); end
   endtask

   task automatic test_crc_error();
      start_meas("crc_write");
      serve_read("crc_read", BAD_CRC, 6);
      tick();
      checks++; if (Crc_Error !== 1'b1) begin errors++; $display("FAIL crc_err got %0b want 1", Crc_Error); end
      checks++; if (Data_Valid !== 1'b0) begin errors++; $display("FAIL crc_dv got %0b want 0", Data_Valid); end
      checks++; if ({Temp_Raw, Hum_Raw} !== 32'hBEEF6666) begin errors++; $display("FAIL crc_hold got %h want beef6666", {Temp_Raw, Hum_Raw}); end
      tick();
      checks++; if (Crc_Error !== 1'b0) begin errors++; $display("FAIL crc_one_cycle got %0b want 0", Crc_Error); end
   endtask

   // Five bytes leave a stale byte 5 that happens to match; the short count must still fail.
   task automatic test_byte_count();
      start_meas("short_write");
      serve_read("short_read", GOOD, 5);
      tick();
      checks++; if ({Data_Valid, Crc_Error} !== 2'b01) begin errors++; $display("FAIL short_read got dv/crc %b want 01", {Data_Valid, Crc_Error}); end
      start_meas("long_write");
      serve_read("long_read", GOOD, 7);
      tick();
      checks++; if ({Data_Valid, Crc_Error} !== 2'b10) begin errors++; $display("FAIL seventh_byte got dv/crc %b want 10", {Data_Valid, Crc_Error}); end
      checks++; if (Temp_Raw !== 16'hBEEF) begin errors++; $display("FAIL seventh_temp got %h want beef", Temp_Raw); end
   endtask

   task automatic test_nack();
      int seen;
      start_meas("nack_write");
      Master_Nack = 1'b1;
      tick();
      Master_Nack = 1'b0;
      checks++; if (Nack_Error !== 1'b1) begin errors++; $display("FAIL nack_err got %0b want 1", Nack_Error); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL nack_idle got %0b want 0", Busy); end
      seen = 0;
      for (int i = 0; i < 80; i++) begin
         tick();
         if (Processor_Ready === 1'b1) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL nack_no_read got %0d pulses want 0", seen); end
      start_meas("nack_done_write");
      Master_Nack = 1'b1;
      Master_Done = 1'b1;
      tick();
      Master_Nack = 1'b0;
      Master_Done = 1'b0;
      checks++; if ({Nack_Error, Busy} !== 2'b10) begin errors++; $display("FAIL nack_priority got nack/busy %b want 10", {Nack_Error, Busy}); end
      checks++; if ({Temp_Raw, Hum_Raw} !== 32'hBEEF6666) begin errors++; $display("FAIL nack_hold got %h want beef6666", {Temp_Raw, Hum_Raw}); end
   endtask

   task automatic test_back_to_back();
      int seen;
      start_meas("b2b_write");
      pulse_done();
      repeat (5) tick();
      Start_Req = 1'b1;
      tick();
      Start_Req = 1'b0;
      wait_ready("b2b_read", 80, seen);
      for (int i = 0; i < 6; i++) begin
         Rx_Valid = 1'b1;
         Rx_Byte  = GOOD[47 - 8*i -: 8];
         tick();
      end
      Rx_Valid = 1'b0;
      pulse_done();
      tick();
      checks++; if (Data_Valid !== 1'b1) begin errors++; $display("FAIL b2b_dv got %0b want 1", Data_Valid); end
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (Processor_Ready === 1'b1) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL busy_start_dropped got %0d pulses want 0", seen); end
   endtask

   task automatic test_reset_mid();
      int bad;
      start_meas("rm_write");
      pulse_done();
      wait_ready("rm_read", 80, bad);
      for (int i = 0; i < 2; i++) begin
         Rx_Valid = 1'b1;
         Rx_Byte  = GOOD[47 - 8*i -: 8];
         tick();
      end
      Rx_Valid = 1'b0;
      rst = 1'b1;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if ({Processor_Ready, Data_Valid, Crc_Error, Nack_Error, Busy} !== 5'b0) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL rm_pulses got %0d bad cycles want 0", bad); end
      checks++; if ({Temp_Raw, Hum_Raw} !== 32'h0) begin errors++; $display("FAIL rm_data got %h want 00000000", {Temp_Raw, Hum_Raw}); end
      rst = 1'b0;
      tick();
      checks++; if ({Busy, Crc_Error, Nack_Error} !== 3'b000) begin errors++; $display("FAIL rm_after got %b want 000", {Busy, Crc_Error, Nack_Error}); end
      start_meas("rm2_write");
      serve_read("rm2_read", GOOD, 6);
      tick();
      checks++; if (Data_Valid !== 1'b1) begin errors++; $display("FAIL rm2_dv got %0b want 1", Data_Valid); end
      checks++; if ({Temp_Raw, Hum_Raw} !== 32'hBEEF6666) begin errors++; $display("FAIL rm2_data got %h want beef6666", {Temp_Raw, Hum_Raw}); end
   endtask

   task automatic test_auto();
      int n, prev, now, seen;
      Auto_En = 1'b1;
      prev = 0;
      for (int k = 0; k < 3; k++) begin
         wait_ready("auto_write", 1100, n);
         now = cyc;
         checks++; if (r_or_w !== 1'b0) begin errors++; $display("FAIL auto_rw[%0d] got %0b want 0", k, r_or_w); end
         if (k > 0) begin
            checks++; if (now - prev !== 1000) begin errors++; $display("FAIL auto_period[%0d] got %0d want 1000", k, now - prev); end
         end
         prev = now;
         if (k == 0) begin
            Start_Req = 1'b1;
            tick();
            Start_Req = 1'b0;
         end
         serve_read("auto_read", GOOD, 6);
         tick();
         checks++; if (Data_Valid !== 1'b1) begin errors++; $display("FAIL auto_dv[%0d] got %0b want 1", k, Data_Valid); end
         tick();
      end
      Auto_En = 1'b0;
      seen = 0;
      for (int i = 0; i < 1100; i++) begin
         tick();
         if (Processor_Ready === 1'b1) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL auto_off got %0d pulses want 0", seen); end
   endtask

   initial begin
      test_reset();
      test_good_read();
      test_crc_error();
      test_byte_count();
      test_nack();
      test_back_to_back();
      test_reset_mid();
      test_auto();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sht40_sequencer.md
SHT40_SEQUENCER -- requirements
Module: sht40_sequencer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- SHT_ADDR, 7'h44, sensor I2C address.
- MEAS_CMD, 8'hFD, high-precision measure command.
- MEAS_WAIT, 200000, clk cycles between write done and read start (10 ms at 20 MHz).
- PERIOD, 20000000, auto-mode cycles between measurement starts (1 s at 20 MHz).
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- Start_Req, in, 1, one-cycle pulse requesting one measurement.
- Auto_En, in, 1, level; enables periodic measurements every PERIOD cycles.
- Processor_Ready, out, 1, one-cycle pulse that launches an I2C transaction.
- Peripheral_Address, out, 7, constant SHT_ADDR.
- r_or_w, out, 1, 0 = write, 1 = read; valid with Processor_Ready.
- Tx_Byte, out, 8, command byte for a write (MEAS_CMD).
- i2c_writes, out, 3, write byte count (1).
- SHT_Reads, out, 4, read byte count (6).
- Master_Done, in, 1, pulse when the master reaches its stop condition.
- Master_Nack, in, 1, pulse when the master sees a NACK.
- Rx_Valid, in, 1, pulse when one received byte is valid.
- Rx_Byte, in, 8, received byte.
- Busy, out, 1, high whenever state != IDLE.
- Temp_Raw, out, 16, last good temperature word.
- Hum_Raw, out, 16, last good humidity word.
- Data_Valid, out, 1, one-cycle pulse when new Temp_Raw/Hum_Raw are committed.
- Crc_Error, out, 1, one-cycle pulse on a CRC mismatch.
- Nack_Error, out, 1, one-cycle pulse on a NACK abort.

Function
REQ-004 States: IDLE, CMD, CMD_WAIT, MEAS_DLY, RD, RD_WAIT, CHECK.
REQ-005 IDLE -> CMD when Start_Req=1, or when Auto_En=1 and the period timer equals PERIOD-1; the period timer resets to 0 on that transition.
REQ-006 CMD issues one Processor_Ready pulse with r_or_w=0 and Tx_Byte=MEAS_CMD, then moves to CMD_WAIT.
REQ-007 CMD_WAIT -> MEAS_DLY on Master_Done.
REQ-008 MEAS_DLY counts MEAS_WAIT cycles (0..MEAS_WAIT-1), then moves to RD.
REQ-009 RD issues one Processor_Ready pulse with r_or_w=1, then moves to RD_WAIT.
REQ-010 RD_WAIT stores Rx_Byte into a 6-entry buffer at index 0..5 on each Rx_Valid.
- A 7th Rx_Valid is ignored; the index saturates at 6.
- RD_WAIT -> CHECK on Master_Done.
REQ-011 CHECK is one cycle.
- Computes CRC-8 (poly 0x31, init 0xFF, no reflection, no final XOR) over bytes {0,1} versus byte 2, and over bytes {3,4} versus byte 5.
- If both match and 6 bytes were received: Temp_Raw={b0,b1}, Hum_Raw={b3,b4}, Data_Valid pulse.
- Otherwise: Crc_Error pulse and outputs unchanged.
- Then -> IDLE.
REQ-012 Master_Nack in CMD_WAIT or RD_WAIT produces a Nack_Error pulse and -> IDLE; Temp_Raw/Hum_Raw are unchanged.
REQ-013 Start_Req outside IDLE is dropped. A pending auto tick outside IDLE is held and serviced on the first IDLE cycle.
REQ-014 Master_Done and Master_Nack in the same cycle: Nack takes priority.
REQ-015 Period timer behaviour:
- Free-runs while Auto_En=1.
- Clears to 0 when Auto_En=0.
- Saturates at PERIOD-1 until consumed.
REQ-016 Peripheral_Address, i2c_writes and SHT_Reads are constant outputs.

Reset
REQ-017 While rst=1:
- State=IDLE; all counters and the buffer are zero.
- Temp_Raw=0, Hum_Raw=0.
- Processor_Ready, Data_Valid, Crc_Error, Nack_Error and Busy are 0.
REQ-018 Reset mid-transaction aborts with no error pulse. The first cycle after reset is IDLE.

Structure
REQ-019 The shared package holds:
- state encoding;
- SHT_ADDR, MEAS_CMD, CRC_POLY=8'h31, CRC_INIT=8'hFF;
- byte counts 1 and 6.
REQ-020 One sub-module, sht40_crc8: combinational CRC-8 of a 16-bit word; two instances are used.

Verification
REQ-021 Start_Req, master model returns BE EF 92 66 66 93 -> Temp_Raw=16'hBEEF, Hum_Raw=16'h6666, one Data_Valid pulse.
REQ-022 Same sequence with byte 2 = 0x93 -> Crc_Error pulse; Temp_Raw/Hum_Raw keep prior values.
REQ-023 Master_Nack during CMD_WAIT -> Nack_Error pulse, IDLE next cycle, no read launched.
REQ-024 Measure the cycles from Master_Done in CMD_WAIT to the second Processor_Ready, with MEAS_WAIT=50 -> exactly 52 cycles (50 delay plus RD entry plus pulse).
REQ-025 Auto_En=1 with PERIOD=1000 -> Processor_Ready write pulses exactly 1000 cycles apart; a Start_Req during Busy is ignored.
REQ-026 rst asserted during RD_WAIT -> all outputs zero, no pulses; a new Start_Req completes normally.
